// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID input, register-file, WB and ID/EX signal bundle for the decode stage.
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [31:0]     id_pc;
  logic [31:0]     id_instr;
  logic            flush;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rf_readReg1;
  logic [4:0]      rf_readReg2;
  logic [XLEN-1:0] rf_readData1;
  logic [XLEN-1:0] rf_readData2;
  logic            rf_writeEnable;
  logic [4:0]      rf_writeReg;
  logic [XLEN-1:0] rf_writeData;
  logic            stall;
  logic            ex_valid;
  logic [31:0]     ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  modport master (
    output id_valid, id_pc, id_instr, flush, wb_we, wb_rd, wb_data, rf_readData1, rf_readData2,
    input  rf_readReg1, rf_readReg2, rf_writeEnable, rf_writeReg, rf_writeData, stall,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
    input  ex_opcode, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write
  );
  modport slave (
    input  id_valid, id_pc, id_instr, flush, wb_we, wb_rd, wb_data, rf_readData1, rf_readData2,
    output rf_readReg1, rf_readReg2, rf_writeEnable, rf_writeReg, rf_writeData, stall,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
    output ex_opcode, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode with WB bypass, x0 forcing, immediate/control generation and load-use stall.
module id_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  id_stage_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  logic [31:0] ins;
  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd, use_rs1, use_rs2;
  logic is_r, is_i, is_ld, is_jalr, is_s, is_b, is_u, is_jal;
  logic rs1_used, rs2_used, reg_write, stall;
  logic [XLEN-1:0] imm, op1, op2;
  assign ins = bus.id_instr;
  assign opc = ins[6:0];
  assign rd  = ins[11:7];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign is_r    = opc == OP_R;
  assign is_i    = opc == OP_I;
  assign is_ld   = opc == OP_LOAD;
  assign is_jalr = opc == OP_JALR;
  assign is_s    = opc == OP_STORE;
  assign is_b    = opc == OP_BR;
  assign is_u    = opc == OP_LUI || opc == OP_AUIPC;
  assign is_jal  = opc == OP_JAL;
  assign rs1_used  = is_r | is_i | is_ld | is_jalr | is_s | is_b;
  assign rs2_used  = is_r | is_s | is_b;
  assign use_rs1   = rs1_used ? rs1 : 5'd0;
  assign use_rs2   = rs2_used ? rs2 : 5'd0;
  assign reg_write = (is_r | is_i | is_ld | is_jalr | is_jal | is_u) & (rd != 5'd0);
  assign imm = (is_i | is_ld | is_jalr) ? {{20{ins[31]}}, ins[31:20]}
             : is_s   ? {{20{ins[31]}}, ins[31:25], ins[11:7]}
             : is_b   ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}
             : is_u   ? {ins[31:12], 12'b0}
             : is_jal ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}
             : '0;
  // The regfile writes at the edge, so a same-cycle WB result must be bypassed here
  assign op1 = (rs1 == 5'd0) ? '0 : (bus.wb_we && bus.wb_rd == rs1) ? bus.wb_data : bus.rf_readData1;
  assign op2 = (rs2 == 5'd0) ? '0 : (bus.wb_we && bus.wb_rd == rs2) ? bus.wb_data : bus.rf_readData2;
  assign bus.rf_readReg1    = rs1;
  assign bus.rf_readReg2    = rs2;
  assign bus.rf_writeEnable = bus.wb_we & (bus.wb_rd != 5'd0);
  assign bus.rf_writeReg    = bus.wb_rd;
  assign bus.rf_writeData   = bus.wb_data;
  assign stall = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0)
               & ((rs1_used & (bus.ex_rd == rs1)) | (rs2_used & (bus.ex_rd == rs2))) & ~bus.flush;
  assign bus.stall = stall;
  always_ff @(posedge clk) begin
    if (rst || bus.flush || stall || !bus.id_valid) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_pc        <= RESET_PC;
      bus.ex_rs1_data  <= '0;
      bus.ex_rs2_data  <= '0;
      bus.ex_imm       <= '0;
      bus.ex_rs1       <= '0;
      bus.ex_rs2       <= '0;
      bus.ex_rd        <= '0;
      bus.ex_opcode    <= '0;
      bus.ex_funct3    <= '0;
      bus.ex_funct7b5  <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
    end else begin
      bus.ex_valid     <= 1'b1;
      bus.ex_pc        <= bus.id_pc;
      bus.ex_rs1_data  <= op1;
      bus.ex_rs2_data  <= op2;
      bus.ex_imm       <= imm;
      bus.ex_rs1       <= use_rs1;
      bus.ex_rs2       <= use_rs2;
      bus.ex_rd        <= rd;
      bus.ex_opcode    <= opc;
      bus.ex_funct3    <= ins[14:12];
      bus.ex_funct7b5  <= ins[30];
      bus.ex_reg_write <= reg_write;
      bus.ex_mem_read  <= is_ld;
      bus.ex_mem_write <= is_s;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for id_stage, checked every cycle against a format-level decode model.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  id_stage_if #(.XLEN(32)) bus ();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5, rw, mr, mw;
  } ex_t;
  logic [31:0] regs [32];
  bit rf_init;
  bit armed;
  ex_t exp_ex;
  ex_t act;
  // Register file that powers up as reg[i]=i, writes at the edge, reads asynchronously
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
      rf_init <= 1'b1;
    end else if (bus.wb_we && bus.wb_rd != 5'd0) regs[bus.wb_rd] <= bus.wb_data;
  end
  assign bus.rf_readData1 = regs[bus.rf_readReg1];
  assign bus.rf_readData2 = regs[bus.rf_readReg2];
  function automatic logic [31:0] m_src(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_rd == i) return bus.wb_data;
    return regs[i];
  endfunction
  function automatic ex_t m_decode(input logic [31:0] pc, input logic [31:0] w);
    ex_t e;
    logic [7:0] fmt;
    e = '0;
    case (w[6:0])
      7'h33:               fmt = "R";
      7'h13, 7'h03, 7'h67: fmt = "I";
      7'h23:               fmt = "S";
      7'h63:               fmt = "B";
      7'h37, 7'h17:        fmt = "U";
      7'h6F:               fmt = "J";
      default:             fmt = "?";
    endcase
    case (fmt)
      "I":     e.imm = 32'($signed(w[31:20]));
      "S":     e.imm = 32'($signed({w[31:25], w[11:7]}));
      "B":     e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
      "U":     e.imm = {w[31:12], 12'd0};
      "J":     e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
      default: e.imm = 32'd0;
    endcase
    e.valid = 1'b1;
    e.pc    = pc;
    e.d1    = m_src(w[19:15]);
    e.d2    = m_src(w[24:20]);
    e.rs1   = (fmt inside {"R", "I", "S", "B"}) ? w[19:15] : 5'd0;
    e.rs2   = (fmt inside {"R", "S", "B"}) ? w[24:20] : 5'd0;
    e.rd    = w[11:7];
    e.op    = w[6:0];
    e.f3    = w[14:12];
    e.f7b5  = w[30];
    e.rw    = (fmt inside {"R", "I", "U", "J"}) && w[11:7] != 5'd0;
    e.mr    = w[6:0] == 7'h03;
    e.mw    = w[6:0] == 7'h23;
    return e;
  endfunction
  function automatic logic m_stall();
    ex_t d;
    d = m_decode(bus.id_pc, bus.id_instr);
    return bus.id_valid && exp_ex.valid && exp_ex.mr && exp_ex.rd != 5'd0 && !bus.flush
        && (exp_ex.rd == d.rs1 || exp_ex.rd == d.rs2);
  endfunction
  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    exp_ex <= (rst || bus.flush || m_stall() || !bus.id_valid) ? '0 : m_decode(bus.id_pc, bus.id_instr);
  end
  task automatic chk(input string name, input logic [255:0] a, input logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (armed) begin
      act = {bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_rs1,
             bus.ex_rs2, bus.ex_rd, bus.ex_opcode, bus.ex_funct3, bus.ex_funct7b5,
             bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write};
      chk("ex_state", act, exp_ex);
      chk("stall", bus.stall, m_stall());
      chk("rf_we", bus.rf_writeEnable, bus.wb_we && bus.wb_rd != 5'd0);
      chk("rf_wport", {bus.rf_writeReg, bus.rf_writeData}, {bus.wb_rd, bus.wb_data});
      chk("rf_raddr", {bus.rf_readReg1, bus.rf_readReg2}, {bus.id_instr[19:15], bus.id_instr[24:20]});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] w);
    bus.id_valid = v;
    bus.id_pc    = pc;
    bus.id_instr = w;
  endtask
  localparam logic [31:0] ADDI   = 32'hFFF08293;
  localparam logic [31:0] LW     = 32'h0000A203;
  localparam logic [31:0] ADD_HZ = 32'h00220333;
  localparam logic [31:0] ADD_OK = 32'h00838333;
  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.wb_we = 1'b0;
    bus.wb_rd = 5'd0;
    bus.wb_data = 32'd0;
    drv(1'b0, 32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", bus.ex_valid, 1'b0);
    chk("reset_pc", bus.ex_pc, 32'd0);
    drv(1'b1, 32'h100, ADDI);
    tick();
    chk("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", bus.ex_rd, 5'd5);
    chk("addi_rw", bus.ex_reg_write, 1'b1);
    chk("addi_rs2", bus.ex_rs2, 5'd0);
    chk("addi_d1", bus.ex_rs1_data, 32'd1);
    drv(1'b1, 32'h104, 32'hFE000EE3);
    tick();
    chk("beq_imm", bus.ex_imm, 32'hFFFFFFFC);
    chk("beq_rw", bus.ex_reg_write, 1'b0);
    drv(1'b1, 32'h108, 32'h123451B7);
    tick();
    chk("lui_imm", bus.ex_imm, 32'h12345000);
    chk("lui_rs1", bus.ex_rs1, 5'd0);
    drv(1'b1, 32'h10C, 32'h0020A423);
    tick();
    chk("sw_imm", bus.ex_imm, 32'd8);
    chk("sw_ctl", {bus.ex_mem_write, bus.ex_reg_write, bus.ex_rs2}, {1'b1, 1'b0, 5'd2});
    drv(1'b1, 32'h110, 32'hFF9FF0EF);
    tick();
    chk("jal_imm", bus.ex_imm, 32'hFFFFFFF8);
    chk("jal_ctl", {bus.ex_reg_write, bus.ex_rs1}, {1'b1, 5'd0});
    drv(1'b1, 32'h114, 32'h0000007F);
    tick();
    chk("unk_ctl", {bus.ex_valid, bus.ex_imm, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
        {1'b1, 32'd0, 3'b000});
    bus.wb_we = 1'b1;
    bus.wb_rd = 5'd1;
    bus.wb_data = 32'hDEAD;
    drv(1'b1, 32'h118, 32'h00008133);
    #1;
    chk("wb_we_x1", bus.rf_writeEnable, 1'b1);
    tick();
    chk("byp_d1", bus.ex_rs1_data, 32'hDEAD);
    chk("byp_d2", bus.ex_rs2_data, 32'd0);
    bus.wb_rd = 5'd0;
    bus.wb_data = 32'h5;
    #1;
    chk("wb_we_x0", bus.rf_writeEnable, 1'b0);
    tick();
    bus.wb_we = 1'b0;
    drv(1'b1, 32'h120, LW);
    tick();
    drv(1'b1, 32'h124, ADD_HZ);
    #1;
    chk("lu_stall", bus.stall, 1'b1);
    tick();
    chk("lu_bubble", bus.ex_valid, 1'b0);
    chk("lu_stall_once", bus.stall, 1'b0);
    tick();
    chk("lu_resume", {bus.ex_valid, bus.ex_rs1, bus.ex_pc}, {1'b1, 5'd4, 32'h124});
    drv(1'b1, 32'h130, LW);
    tick();
    drv(1'b1, 32'h134, ADD_OK);
    #1;
    chk("nolu_stall", bus.stall, 1'b0);
    tick();
    chk("nolu_valid", {bus.ex_valid, bus.ex_pc}, {1'b1, 32'h134});
    drv(1'b1, 32'h140, LW);
    tick();
    drv(1'b1, 32'h144, ADD_HZ);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", bus.stall, 1'b0);
    tick();
    chk("flush_bubble", bus.ex_valid, 1'b0);
    bus.flush = 1'b0;
    drv(1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 32'h200 + 32'(4 * i), {7'd0, 5'(i + 1), 5'(i), 3'd0, 5'(8 + i), 7'h33});
      tick();
      chk("b2b_valid", bus.ex_valid, 1'b1);
      chk("b2b_pc", bus.ex_pc, 32'h200 + 32'(4 * i));
    end
    drv(1'b1, 32'h300, ADDI);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid", {bus.ex_valid, bus.ex_imm, bus.ex_rd, bus.ex_pc}, {1'b0, 32'd0, 5'd0, 32'd0});
    tick();
    rst = 1'b0;
    tick();
    chk("rst_resume", {bus.ex_valid, bus.ex_imm, bus.ex_pc}, {1'b1, 32'hFFFFFFFF, 32'h300});
    drv(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline.
- Consumes the IF/ID instruction and drives the register-file read addresses. It receives the asynchronous read data back and applies WB bypass and x0 forcing, then generates the immediate and control signals.
- Registers the result into the ID/EX pipeline register.
- Also gates the WB write port into the register file, and owns load-use hazard detection.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, ex_pc value loaded on reset/bubble (informational only)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_pc  in  32  PC of IF/ID instruction
- id_instr  in  32  IF/ID instruction word
- flush  in  1  branch/jump taken in EX; kill ID
- wb_we  in  1  WB stage write request
- wb_rd  in  5  WB destination
- wb_data  in  32  WB write data
- rf_readReg1  out  5  to register file readReg1 (= instr[19:15])
- rf_readReg2  out  5  to register file readReg2 (= instr[24:20])
- rf_readData1  in  32  from register file
- rf_readData2  in  32  from register file
- rf_writeEnable  out  1  to register file; wb_we & (wb_rd != 0)
- rf_writeReg  out  5  = wb_rd
- rf_writeData  out  32  = wb_data
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  ID/EX valid
- ex_pc  out  32
- ex_rs1_data, ex_rs2_data  out  32 each  bypassed operands
- ex_imm  out  32  sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5 each
- ex_opcode  out  7
- ex_funct3  out  3
- ex_funct7b5  out  1
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each

Behaviour:
- Reset (rst=1 at edge): all ex_* outputs go to 0; ex_pc goes to RESET_PC. Reset has priority over flush and stall. Reset mid-stream discards the ID/EX content.
- Register file is written at posedge and read asynchronously. A same-cycle WB write is therefore not visible on rf_readData. Operand select per source, in priority order:
  - index == 0 -> 0. The register file powers up with reg[i]=i and does not protect x0 itself.
  - wb_we && wb_rd == index && wb_rd != 0 -> wb_data.
  - otherwise -> rf_readData.
- Writes to x0 are suppressed via rf_writeEnable.
- Immediate by opcode, bit-exact RV32I:
  - I (0010011, 0000011, 1100111): sign-extend instr[31:20].
  - S (0100011): sign-extend {instr[31:25], instr[11:7]}.
  - B (1100011): sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J (1101111): sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Other opcodes: 0.
- Controls:
  - reg_write = 1 for R, I-ALU, load, JAL, JALR, LUI, AUIPC. Forced to 0 when rd == 0.
  - mem_read = 1 for load.
  - mem_write = 1 for store.
  - Unknown opcode -> all controls 0, instruction still passes as valid.
- Source-use rules:
  - rs1 is used by all formats except U and J.
  - rs2 is used by R, S and B only.
  - ex_rs1/ex_rs2 output 0 when the source is unused, so EX forwarding never matches a stale field.
- Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((rs1 used & ex_rd == rs1) | (rs2 used & ex_rd == rs2)) & !flush.
- ID/EX update each edge, in priority order:
  - rst -> zero.
  - flush -> bubble (all ex_* 0, ex_valid=0).
  - stall -> bubble; the IF/ID instruction is held upstream and re-decoded next cycle.
  - id_valid=0 -> bubble.
  - else -> load the decoded values, ex_valid=1.
- Latency: 1 cycle from IF/ID to ID/EX. A stall inserts exactly one bubble per load-use pair.
- flush with stall simultaneously: flush wins and stall is deasserted.
- A WB write and a read of the same register in the same cycle return wb_data.

Test Plan:
- Reset: assert rst 2 cycles mid-stream with a valid addi -> all ex_* = 0 and ex_valid=0 at the first edge after rst. Normal decode resumes one cycle after rst drops.
- Decode/imm:
  - addi x5,x1,-1 (0xFFF08293) -> ex_imm=0xFFFFFFFF, ex_rd=5, ex_reg_write=1, ex_rs2=0.
  - beq with offset -4 -> ex_imm=0xFFFFFFFC.
  - lui x3,0x12345 -> ex_imm=0x12345000.
- WB bypass / x0:
  - wb_we=1, wb_rd=1, wb_data=0xDEAD while decoding add x2,x1,x0 with rf_readData1=1 -> ex_rs1_data=0xDEAD, ex_rs2_data=0.
  - wb_we=1, wb_rd=0 -> rf_writeEnable=0.
- Load-use:
  - lw x4,0(x1) followed by add x6,x4,x2 -> stall=1 for exactly one cycle and one bubble (ex_valid=0) is inserted.
  - add enters EX the next cycle with ex_rs1=4.
  - Same pair with add x6,x7,x8 -> no stall.
- Flush priority: flush=1 during the load-use stall cycle -> stall=0 and ex_valid=0 at the next edge.
- Back-to-back: 10 valid R-type instructions with id_valid held at 1 -> ex_valid=1 every cycle, ex_pc tracks id_pc delayed by one cycle.
